// File: rtl/fir_mac_engine.sv
// Sequential 64-tap FIR engine: one multiply-accumulate per clock against an external coefficient ROM.
// Optional FIR_ROUND_EN macro selects round-half-up before the output shift (default: floor).
module fir_mac_engine #(
  parameter int WIDTH     = 16,
  parameter int TAPS      = 64,
  parameter int ADR_W     = 6,
  parameter int ACC_W     = 40,
  parameter int OUT_SHIFT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [ADR_W-1:0] coef_adr,
  input  logic [WIDTH-1:0] coef_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // a valid source holds its data stable until that edge, and ready never depends on valid.

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W+2-WIDTH){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W+2-WIDTH){1'b1}}, {(WIDTH-1){1'b0}}};
`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W:0] ROUND_BIAS =
    {{(ACC_W+1-OUT_SHIFT){1'b0}}, 1'b1, {(OUT_SHIFT-1){1'b0}}};
`else
  localparam logic signed [ACC_W:0] ROUND_BIAS = '0;
`endif

  state_t                   state_q, state_d;
  logic [ADR_W-1:0]         wptr_q, wptr_d;
  logic [ADR_W-1:0]         k_q, k_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [WIDTH-1:0]         buf_q [TAPS];
  logic [WIDTH-1:0]         buf_d [TAPS];
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;

  logic [ADR_W-1:0]         rd_idx;
  logic signed [2*WIDTH-1:0] prod;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W:0]    rnd_acc;
  logic signed [ACC_W:0]    shifted;
  logic [WIDTH-1:0]         sat_out;

  // Newest sample sits at wptr; tap k reads k samples back, wrapping modulo TAPS.
  assign rd_idx  = wptr_q - k_q;
  assign prod    = $signed(coef_in) * $signed(buf_q[rd_idx]);
  assign acc_sum = acc_q + {{(ACC_W-2*WIDTH){prod[2*WIDTH-1]}}, prod};
  assign rnd_acc = {acc_sum[ACC_W-1], acc_sum} + ROUND_BIAS;
  assign shifted = rnd_acc >>> OUT_SHIFT;

  always_comb begin
    sat_out = shifted[WIDTH-1:0];
    if (shifted > SAT_MAX) begin
      sat_out = SAT_MAX[WIDTH-1:0];
    end else if (shifted < SAT_MIN) begin
      sat_out = SAT_MIN[WIDTH-1:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    k_d        = k_q;
    acc_d      = acc_q;
    buf_d      = buf_q;
    out_data_d = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          buf_d[wptr_q] = in_data;
          acc_d         = '0;
          k_d           = '0;
          state_d       = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_sum;
        if (k_q == ADR_W'(TAPS-1)) begin
          wptr_d     = wptr_q + ADR_W'(1);
          k_d        = '0;
          out_data_d = sat_out;
          state_d    = S_OUT;
        end else begin
          k_d = k_q + ADR_W'(1);
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // k is parked at zero outside MAC, so it doubles as the ROM address.
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wptr_q      <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      k_q         <= k_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      buf_q       <= buf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign coef_adr  = k_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine: bench-owned coefficient table, sample-history reference model,
// every-cycle output/handshake compare, plus literal impulse/rounding/saturation expectations.
module tb_fir_mac_engine;

  localparam int WIDTH     = 16;
  localparam int TAPS      = 64;
  localparam int ADR_W     = 6;
  localparam int ACC_W     = 40;
  localparam int OUT_SHIFT = 15;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic [ADR_W-1:0] coef_adr;
  logic [WIDTH-1:0] coef_in;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;

  fir_mac_engine #(
    .WIDTH(WIDTH), .TAPS(TAPS), .ADR_W(ADR_W), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .coef_adr(coef_adr), .coef_in(coef_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Coefficient ROM stand-in: table lookup, or a constant 32767 for the clamp tests.
  logic signed [WIDTH-1:0] coef_tbl [TAPS];
  bit sat_mode = 1'b0;
  always_comb coef_in = sat_mode ? 16'sh7fff : coef_tbl[coef_adr];

  // out_ready changes 2 time units after each rising edge.
  bit rdy_mode = 1'b0;
  bit rdy_val  = 1'b0;
  always @(posedge clk) begin
    #2;
    out_ready = rdy_mode ? 1'($urandom_range(0, 1)) : rdy_val;
  end

  // ---------------- scoreboard / model ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] exp_q[$];
  longint out_log[$];
  longint hist [TAPS];
  bit tracking = 1'b0;
  int acc_cyc  = 0;
  int prev_acc = -1;
  int mon_d;

  task automatic check(input string name, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic longint coef_val(input int k);
    return sat_mode ? 64'sd32767 : longint'(coef_tbl[k]);
  endfunction

  // y = sat( floor((sum_k c[k]*x[n-k] [+ 2^(S-1)]) / 2^S) )
  function automatic longint model_out();
    longint sum = 0;
    longint y;
    for (int k = 0; k < TAPS; k++) sum += coef_val(k) * hist[k];
`ifdef FIR_ROUND_EN
    sum += (64'sd1 <<< (OUT_SHIFT - 1));
`endif
    y = sum >>> OUT_SHIFT;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    return y;
  endfunction

  task automatic model_push(input logic signed [WIDTH-1:0] v);
    for (int k = TAPS - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = longint'(v);
    exp_q.push_back(WIDTH'(model_out()));
  endtask

  task automatic model_clear();
    for (int k = 0; k < TAPS; k++) hist[k] = 0;
    exp_q.delete();
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (rst) begin
      if (out_valid) begin
        check("in_ready_low_in_out", longint'(in_ready), 0);
        if (exp_q.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          check("out_data", longint'($signed(out_data)), longint'($signed(exp_q[0])));
          if (out_ready) begin
            out_log.push_back(longint'($signed(out_data)));
            void'(exp_q.pop_front());
          end
        end
      end
      if (tracking) begin
        mon_d = cyc - acc_cyc;
        if (mon_d >= 1 && mon_d <= TAPS) begin
          check("coef_adr_seq", longint'(coef_adr), longint'(mon_d - 1));
          check("out_valid_low_mac", longint'(out_valid), 0);
          check("in_ready_low_mac", longint'(in_ready), 0);
        end else if (mon_d == TAPS + 1) begin
          check("latency_out_valid", longint'(out_valid), 1);
          check("coef_adr_out", longint'(coef_adr), 0);
          tracking = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_now(input int n);
    rst = 1'b0;
    tracking = 1'b0;
    prev_acc = -1;
    model_clear();
    repeat (n) begin
      @(negedge clk);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_out_data", longint'(out_data), 0);
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_coef_adr", longint'(coef_adr), 0);
    end
    rst = 1'b1;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    reset_now(n);
  endtask

  task automatic send_sample(input logic signed [WIDTH-1:0] v, input bit hold);
    int waited = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = v;
    while (!in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    if (hold && prev_acc >= 0) check("accept_period", longint'(cyc - prev_acc), TAPS + 2);
    prev_acc = cyc;
    acc_cyc  = cyc;
    tracking = 1'b1;
    model_push(v);
    @(posedge clk);
    if (!hold) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int waited = 0;
    while ((exp_q.size() != 0 || tracking) && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check("drain_timeout", longint'(exp_q.size()), 0);
    in_valid = 1'b0;
  endtask

  task automatic run_impulse();
    out_log.delete();
    send_sample(16'sh8000, 1'b0);
    for (int i = 1; i < TAPS; i++) send_sample(16'sh0000, 1'b0);
    wait_drain();
    check("impulse_count", longint'(out_log.size()), TAPS);
    if (out_log.size() == TAPS) begin
      check("impulse_y0", out_log[0], -121);
      check("impulse_y1", out_log[1], -96);
      check("impulse_y2", out_log[2], 54);
      check("impulse_y3", out_log[3], 310);
      check("impulse_y63", out_log[63], -121);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] held;
    int waited;

    coef_tbl[0] = 16'sd121;
    coef_tbl[1] = 16'sd96;
    coef_tbl[2] = -16'sd54;
    coef_tbl[3] = -16'sd310;
    for (int k = 4; k < TAPS - 1; k++) coef_tbl[k] = WIDTH'($urandom_range(0, 8191)) - 16'sd4096;
    coef_tbl[TAPS-1] = 16'sd121;
    model_clear();

    // Reset state, then impulse response with random backpressure
    reset_now(3);
    rdy_mode = 1'b1;
    run_impulse();

    // Rounding on a single positive full-scale sample
    do_reset(1);
    out_log.delete();
    send_sample(16'sh7fff, 1'b0);
    wait_drain();
    check("round_count", longint'(out_log.size()), 1);
    if (out_log.size() >= 1) begin
`ifdef FIR_ROUND_EN
      check("round_y0", out_log[0], 121);
`else
      check("round_y0", out_log[0], 120);
`endif
    end

    // Random samples, random gaps, random out_ready
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_sample(WIDTH'($urandom_range(0, 65535)), 1'b0);
    end
    wait_drain();

    // Backpressure: hold out_ready low for 10 cycles once output is up
    rdy_mode = 1'b0;
    rdy_val  = 1'b0;
    send_sample(WIDTH'($urandom_range(0, 65535)), 1'b0);
    waited = 0;
    while (!out_valid && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("bp_out_valid_rise", longint'(out_valid), 1);
    held = out_data;
    repeat (10) begin
      @(negedge clk);
      check("bp_out_valid_hold", longint'(out_valid), 1);
      check("bp_out_data_hold", longint'(out_data), longint'(held));
      check("bp_in_ready_low", longint'(in_ready), 0);
    end
    rdy_val = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("bp_release_out_valid", longint'(out_valid), 0);
    check("bp_release_in_ready", longint'(in_ready), 1);
    wait_drain();

    // in_valid held continuously: one accept per TAPS+2 cycles
    prev_acc = -1;
    for (int i = 0; i < 4; i++) send_sample(WIDTH'($urandom_range(0, 65535)), 1'b1);
    wait_drain();

    // Clamp tests with constant 32767 coefficients
    rdy_mode = 1'b1;
    sat_mode = 1'b1;
    out_log.delete();
    for (int i = 0; i < TAPS; i++) send_sample(16'sh7fff, 1'b0);
    wait_drain();
    if (out_log.size() == TAPS) check("sat_pos_y63", out_log[TAPS-1], 32767);
    else check("sat_pos_count", longint'(out_log.size()), TAPS);
    out_log.delete();
    for (int i = 0; i < TAPS; i++) send_sample(16'sh8000, 1'b0);
    wait_drain();
    if (out_log.size() == TAPS) check("sat_neg_y63", out_log[TAPS-1], -32768);
    else check("sat_neg_count", longint'(out_log.size()), TAPS);
    sat_mode = 1'b0;

    // Reset while the MAC is at k=30, then the impulse must reproduce exactly
    send_sample(WIDTH'($urandom_range(0, 65535)), 1'b0);
    waited = 0;
    while (coef_adr != ADR_W'(30) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("mid_mac_reached_k30", longint'(coef_adr), 30);
    out_log.delete();
    reset_now(1);
    @(negedge clk);
    check("post_rst_in_ready", longint'(in_ready), 1);
    check("post_rst_out_valid", longint'(out_valid), 0);
    check("post_rst_no_output", longint'(out_log.size()), 0);
    run_impulse();

    wait_drain();
    check("final_queue_empty", longint'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fir_mac_engine.md
Name: fir_mac_engine

Overview:
- Sequential 64-tap FIR datapath that sits directly downstream of the coefficient ROM.
- Drives the ROM address and consumes its combinational coefficient output.
- Accepts one input sample per handshake into a 64-entry circular sample buffer, runs one multiply-accumulate per clock across all taps, then presents one saturated output sample.
- Coefficients are signed Q1.15. Samples are signed 16-bit.

Parameters:
WIDTH, 16, sample, coefficient and output width (signed)
TAPS, 64, number of taps; power of two
ADR_W, 6, log2(TAPS); width of coef_adr and buffer pointers
ACC_W, 40, accumulator width (signed); must be at least 2*WIDTH+ADR_W
OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous active-low reset
in_valid  input  1  input sample valid
in_ready  output  1  engine can accept a sample
in_data  input  WIDTH  signed input sample
coef_adr  output  ADR_W  address to the coefficient ROM
coef_in  input  WIDTH  signed coefficient, combinationally valid in the same cycle as coef_adr
out_valid  output  1  filtered sample valid
out_ready  input  1  downstream accepts the output
out_data  output  WIDTH  signed filtered sample

Behaviour:
- Reset: when rst=0 at a clock edge, the following apply and any in-flight computation is discarded without output:
  - state=IDLE, wptr=0, k=0, acc=0
  - all TAPS buffer entries = 0
  - out_valid=0, out_data=0, in_ready=0 during reset, coef_adr=0
- FSM state IDLE:
  - in_ready=1, coef_adr=0.
  - On in_valid&in_ready: buf[wptr]<=in_data, acc<=0, k<=0, go to MAC.
- FSM state MAC:
  - in_ready=0, coef_adr=k.
  - Each cycle: acc <= acc + coef_in * buf[(wptr-k) mod TAPS].
  - The product is a full 2*WIDTH signed value, sign-extended to ACC_W.
  - k=0 uses the sample just written.
  - When k=TAPS-1, the final product is added, wptr<=wptr+1 (wraps TAPS-1 to 0), and the FSM goes to OUT. Otherwise k<=k+1.
- FSM state OUT:
  - out_valid=1, in_ready=0, coef_adr=0.
  - out_data is registered on entry to OUT: y = acc >>> OUT_SHIFT (arithmetic), then saturated to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - out_valid and out_data are held stable while out_ready=0.
  - On out_ready=1, the FSM goes to IDLE and out_valid deasserts the next cycle.
  - out_data retains its last value.
- Latency:
  - The sample is accepted at edge E0. MAC occupies edges E1..E_TAPS.
  - out_valid is high from edge E_TAPS onward, i.e. TAPS cycles after acceptance.
  - Minimum sample period is TAPS+2 cycles.
- Boundary conditions:
  - wptr wrap-around is seamless; history spans the wrap.
  - in_valid while busy is ignored; no sample is lost because in_ready=0.
  - in_valid and out_ready both high in OUT: only the output transfer happens; the sample is taken in IDLE the next cycle.
  - Accumulator cannot overflow at the default parameters (worst case 2^30*64 < 2^39).

Optional Feature:
- Macro: FIR_ROUND_EN.
- Defined: add 2^(OUT_SHIFT-1) to acc before the arithmetic shift (round half up), then saturate. The addition is done at ACC_W width with no wrap.
- Undefined: plain truncation (floor) by arithmetic shift.

Test Plan:
- Impulse, real ROM attached: in_data=-32768 then 63 zeros.
  - Outputs equal the exact negated coefficients: -121, -96, 54, 310, ... ending -121.
  - Identical with and without FIR_ROUND_EN.
- Rounding, real ROM: single sample 32767, read the first output.
  - Expect 120 without FIR_ROUND_EN, 121 with it.
  - Arithmetic: 32767*121 = 3964807; /2^15 = 120.996.
- Saturation, bench drives coef_in=32767 constant:
  - 64 samples of 32767: the 64th output is 32767 (positive clamp).
  - 64 samples of -32768: the 64th output is -32768 (negative clamp).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - out_valid stays 1, out_data is unchanged, in_ready stays 0 throughout.
  - One cycle after out_ready=1: out_valid=0, in_ready=1.
- Latency and handshake: in_valid held continuously.
  - Samples are accepted exactly once every TAPS+2=66 cycles.
  - out_valid rises 64 cycles after each accept.
  - coef_adr sequences 0..63 during MAC.
- Reset mid-MAC: drive rst=0 while k=30.
  - Next cycle: state IDLE, out_valid=0, no output is produced.
  - A subsequent -32768 impulse reproduces the impulse-test outputs exactly, proving the buffer was cleared and wptr=0.
